// File: rtl/wb_sram_slave.sv
// Wishbone classic slave backed by a byte-writable SRAM array, with optional wait states.
// Define WB_SRAM_BOUND_CHK_EN to reject indices >= DEPTH with wbs_err_o; otherwise the index wraps.
module wb_sram_slave #(
  parameter int DW          = 32,
  parameter int AW          = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 0
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic            wbs_we_i,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic [DW/8-1:0] wbs_sel_i,
  output logic [DW-1:0]   wbs_dat_o,
  output logic            wbs_ack_o,
  output logic            wbs_err_o
);

  localparam int NB = DW / 8;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          err_d;
  logic [DW-1:0] dat_q, dat_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic          req;
  logic          exec;
  logic          reject;
  logic          wr_en;
  logic          rd_en;

  assign idx = wbs_adr_i[AW+1:2];
  assign req = wbs_cyc_i & wbs_stb_i;

  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};

`ifdef WB_SRAM_BOUND_CHK_EN
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  logic err_q;

  assign reject = ({1'b0, idx} >= DEPTH_L);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign wbs_err_o = err_q;
`else
  assign reject    = 1'b0;
  assign wbs_err_o = 1'b0;
`endif

  // exec marks the single edge on which the access is performed and the response is registered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exec    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            exec    = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          exec    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign wr_en = exec & wbs_we_i & ~reject;
  assign rd_en = exec & ~wbs_we_i & ~reject;
  assign ack_d = exec & ~reject;
  assign err_d = exec & reject;
  assign dat_d = rd_en ? mem_q[idx] : dat_q;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  // Memory is never cleared; reset only blocks a write landing on the reset edge
  always_ff @(posedge sys_clk) begin
    if (rst_n && wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wbs_sel_i[b]) begin
          mem_q[idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
        end
      end
    end
  end

  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Randomised bench for wb_sram_slave: instances with 0 and 3 wait states (plus a
// DEPTH=300 bound-checked instance when WB_SRAM_BOUND_CHK_EN is defined) against a word-array model.
module tb_wb_sram_slave;

`ifdef WB_SRAM_BOUND_CHK_EN
  localparam int ND = 3;
`else
  localparam int ND = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cyc  [ND];
  logic        stb  [ND];
  logic        we   [ND];
  logic [31:0] adr  [ND];
  logic [31:0] wdat [ND];
  logic [3:0]  sel  [ND];
  logic [31:0] rdat [ND];
  logic        ack  [ND];
  logic        err  [ND];

  int unsigned ws_of    [ND];
  int unsigned depth_of [ND];
  logic [31:0] mdl      [ND][512];
  logic [31:0] mdl_dat  [ND];

  int checks = 0;
  int errors = 0;

  wb_sram_slave #(.DW(32), .AW(9), .DEPTH(512), .WAIT_STATES(0)) u_ws0 (
    .sys_clk(clk), .rst_n(rst_n), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]),
    .wbs_adr_i(adr[0]), .wbs_we_i(we[0]), .wbs_dat_i(wdat[0]), .wbs_sel_i(sel[0]),
    .wbs_dat_o(rdat[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0])
  );

  wb_sram_slave #(.DW(32), .AW(9), .DEPTH(512), .WAIT_STATES(3)) u_ws3 (
    .sys_clk(clk), .rst_n(rst_n), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]),
    .wbs_adr_i(adr[1]), .wbs_we_i(we[1]), .wbs_dat_i(wdat[1]), .wbs_sel_i(sel[1]),
    .wbs_dat_o(rdat[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1])
  );

`ifdef WB_SRAM_BOUND_CHK_EN
  wb_sram_slave #(.DW(32), .AW(9), .DEPTH(300), .WAIT_STATES(1)) u_bnd (
    .sys_clk(clk), .rst_n(rst_n), .wbs_cyc_i(cyc[2]), .wbs_stb_i(stb[2]),
    .wbs_adr_i(adr[2]), .wbs_we_i(we[2]), .wbs_dat_i(wdat[2]), .wbs_sel_i(sel[2]),
    .wbs_dat_o(rdat[2]), .wbs_ack_o(ack[2]), .wbs_err_o(err[2])
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Byte address with random ignored bits around the word index
  function automatic logic [31:0] mk_adr(input int unsigned idx);
    return ($urandom & 32'hFFFF_F800) | ((idx & 32'h1FF) << 2) | ($urandom & 32'h3);
  endfunction

  task automatic access(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] data, input logic [3:0] s);
    int unsigned idx;
    bit          bad;
    int          n;
    bit          done;
    logic [31:0] m;
    idx  = (a >> 2) & 32'h1FF;
    bad  = (idx >= depth_of[d]);
    n    = 0;
    done = 1'b0;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = data; sel[d] = s;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[d] || err[d]) done = 1'b1;
    end
    check("latency", n, 1 + ws_of[d]);
    check("ack", {31'b0, ack[d]}, {31'b0, !bad});
    check("err", {31'b0, err[d]}, {31'b0, bad});
    if (!bad) begin
      if (w) begin
        m = lane_mask(s);
        mdl[d][idx] = (mdl[d][idx] & ~m) | (data & m);
      end else begin
        mdl_dat[d] = mdl[d][idx];
      end
    end
    check("rdata", rdat[d], mdl_dat[d]);
    // strobe still high during the response cycle must not start a new access
    @(negedge clk);
    check("single_pulse", {30'b0, ack[d], err[d]}, 32'd0);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic abort_write(input int d, input logic [31:0] a, input logic [31:0] data);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; adr[d] = a; wdat[d] = data; sel[d] = 4'hF;
    repeat (2) @(negedge clk);
    cyc[d] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack[d] || err[d]) seen = 1'b1;
    end
    check("abort_no_resp", {31'b0, seen}, 32'd0);
    stb[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic reset_in_wait(input int d, input logic [31:0] a, input logic [31:0] data);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; adr[d] = a; wdat[d] = data; sel[d] = 4'hF;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_ack", {31'b0, ack[d]}, 32'd0);
    check("rst_err", {31'b0, err[d]}, 32'd0);
    check("rst_dat", rdat[d], 32'd0);
    for (int k = 0; k < ND; k++) mdl_dat[k] = 32'd0;
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int          d;
    int unsigned idx;
    logic [31:0] a;

    ws_of[0] = 0; depth_of[0] = 512;
    ws_of[1] = 3; depth_of[1] = 512;
`ifdef WB_SRAM_BOUND_CHK_EN
    ws_of[2] = 1; depth_of[2] = 300;
`endif
    for (int k = 0; k < ND; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      adr[k] = '0; wdat[k] = '0; sel[k] = '0;
      mdl_dat[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      check("reset_dat", rdat[k], 32'd0);
      check("reset_resp", {30'b0, ack[k], err[k]}, 32'd0);
    end
    rst_n = 1'b1;

    for (int k = 0; k < ND; k++)
      for (int unsigned i = 0; i < depth_of[k]; i++)
        access(k, 1'b1, mk_adr(i), $urandom, 4'hF);

    // Directed scenarios
    access(0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF);
    access(0, 1'b0, 32'h010, 32'h0, 4'h0);
    check("deadbeef", rdat[0], 32'hDEADBEEF);

    access(0, 1'b1, 32'h040, 32'h11223344, 4'hF);
    access(0, 1'b1, 32'h040, 32'hAABBCCDD, 4'h5);
    access(0, 1'b0, 32'h040, 32'h0, 4'h0);
    check("lane_merge", rdat[0], 32'h11BB33DD);

    access(0, 1'b1, 32'h040, 32'hFFFFFFFF, 4'h0);
    access(0, 1'b0, 32'h040, 32'h0, 4'h0);
    check("sel_zero", rdat[0], 32'h11BB33DD);

    access(1, 1'b1, 32'h020, 32'hCAFEF00D, 4'hF);
    access(1, 1'b0, 32'h020, 32'h0, 4'h0);
    check("ws3_read", rdat[1], 32'hCAFEF00D);

    access(1, 1'b1, 32'h030, 32'h01020304, 4'hF);
    abort_write(1, 32'h030, 32'h5A5A5A5A);
    access(1, 1'b0, 32'h030, 32'h0, 4'h0);
    check("abort_keep", rdat[1], 32'h01020304);

    reset_in_wait(1, 32'h030, 32'h5A5A5A5A);
    access(1, 1'b0, 32'h030, 32'h0, 4'h0);
    check("rst_no_write", rdat[1], 32'h01020304);

    // Ignored upper address bits alias onto the same word
    access(0, 1'b1, 32'hFFFF_F9FC, 32'h0BADC0DE, 4'hF);
    access(0, 1'b0, 32'h0000_01FC, 32'h0, 4'h0);
    check("addr_alias", rdat[0], 32'h0BADC0DE);

`ifdef WB_SRAM_BOUND_CHK_EN
    access(2, 1'b1, 32'h4B0, 32'h5A5A5A5A, 4'hF);
    access(2, 1'b1, 32'h4AC, 32'h299299AB, 4'hF);
    access(2, 1'b0, 32'h4AC, 32'h0, 4'h0);
    check("bound_299", rdat[2], 32'h299299AB);
    access(2, 1'b0, 32'h4B0, 32'h0, 4'h0);
    check("bound_300_dat", rdat[2], 32'h299299AB);
`endif

    for (int unsigned it = 0; it < 400; it++) begin
      d   = int'($urandom_range(0, ND - 1));
      idx = $urandom_range(0, 511);
      a   = mk_adr(idx);
      if ($urandom_range(0, 3) == 0) begin
        access(d, 1'b1, a, $urandom, 4'($urandom));
        access(d, 1'b0, a, 32'h0, 4'h0);
      end else begin
        access(d, 1'($urandom), a, $urandom, 4'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_sram_slave.md
WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

Interface
REQ-001 Parameter DW, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 9: word-address width; the word index SHALL be wbs_adr_i[AW+1:2].
REQ-003 Parameter DEPTH, default 512: number of DW-bit words; SHALL be ≤ 2^AW.
REQ-004 Parameter WAIT_STATES, default 0: extra response cycles per access, range 0..15.
REQ-005 sys_clk  in  1  single clock; all logic SHALL be sampled on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 wbs_cyc_i  in  1  Wishbone bus cycle.
REQ-008 wbs_stb_i  in  1  Wishbone strobe.
REQ-009 wbs_adr_i  in  32  byte address; bits [1:0] and bits above AW+1 are ignored.
REQ-010 wbs_we_i  in  1  1 = write, 0 = read.
REQ-011 wbs_dat_i  in  DW  write data.
REQ-012 wbs_sel_i  in  DW/8  byte-lane write enables.
REQ-013 wbs_dat_o  out  DW  read data.
REQ-014 wbs_ack_o  out  1  access complete.
REQ-015 wbs_err_o  out  1  access rejected.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 In IDLE with cyc&stb high: the FSM SHALL go to WAIT when WAIT_STATES>0 (counter loaded with WAIT_STATES-1), otherwise it SHALL execute the access and go to RESP.
REQ-018 In WAIT: the counter SHALL decrement each cycle; at 0 the FSM SHALL execute the access and go to RESP; if cyc or stb falls, the FSM SHALL return to IDLE with no memory write and no ack/err.
REQ-019 Execute SHALL mean, on one edge: write, read or reject, and set wbs_ack_o (or wbs_err_o) to 1 for the next cycle.
  - Write: update only the byte lanes with wbs_sel_i=1.
  - Read: load wbs_dat_o with mem[index].
  - Reject: see REQ-027.
REQ-020 Request-to-ack latency SHALL be 1+WAIT_STATES cycles, measured from the first cycle cyc&stb is high to the ack-high cycle.
REQ-021 wbs_ack_o and wbs_err_o SHALL be high for exactly one cycle per access and never simultaneously.
REQ-022 In RESP: the FSM SHALL go to IDLE unconditionally; a still-high stb SHALL NOT start a new access in that cycle.
  - Maximum throughput: one access per 2+WAIT_STATES cycles.
REQ-023 wbs_dat_o SHALL hold the last read data; write and reject accesses SHALL leave it unchanged.
REQ-024 A write with wbs_sel_i=0 SHALL be acknowledged and SHALL leave memory unchanged.
REQ-025 Read-after-write to the same index in back-to-back accesses SHALL return the newly written bytes.

Reset
REQ-026 On a sys_clk edge with rst_n=0, regardless of FSM state:
  - state SHALL become IDLE and the wait counter 0;
  - wbs_ack_o and wbs_err_o SHALL become 0;
  - wbs_dat_o SHALL become 0;
  - memory contents SHALL be preserved;
  - an access in WAIT SHALL be abandoned with no write.

Configuration
REQ-027 With macro WB_SRAM_BOUND_CHK_EN defined: an access with index ≥ DEPTH SHALL complete with wbs_err_o after the same latency as REQ-020, with no memory write and wbs_dat_o unchanged.
REQ-028 Without WB_SRAM_BOUND_CHK_EN: wbs_err_o SHALL be tied to 0, DEPTH SHALL equal 2^AW, and every index SHALL address memory directly (wrap modulo DEPTH).

Verification
REQ-029 WAIT_STATES=0: write 0xDEADBEEF to 0x010 with sel=0xF, then read 0x010 → each ack occurs 1 cycle after stb and the read returns 0xDEADBEEF.
REQ-030 Write 0x11223344 with sel=0xF, then write 0xAABBCCDD with sel=0x5, then read → 0x11BB33DD.
REQ-031 WAIT_STATES=3: read 0x020 → ack in cycle 4 after stb; stb held high through RESP → no second ack until stb is reasserted in IDLE.
REQ-032 WAIT_STATES=3: write 0x5A5A5A5A to 0x030, drop cyc in cycle 2 → no ack; a subsequent read of 0x030 returns the prior contents; rst_n=0 asserted during WAIT → ack/err 0 next cycle and FSM in IDLE.
REQ-033 WB_SRAM_BOUND_CHK_EN, DEPTH=300: write to byte address 0x4B0 (index 300) → err pulse for one cycle, no ack, memory unchanged; index 299 → ack.
